// File: rtl/seq_mul32_if.sv
// Request/response bundle between the execute stage and the iterative multiplier.
// start is a request pulse taken only when busy=0 and kill=0; the result is valid only in the cycle done=1.
interface seq_mul32_if;
   logic        start;
   logic        kill;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [1:0]  state;

   modport master (
      output start, kill, op, a, b,
      input  busy, done, result, state
   );

   modport slave (
      input  start, kill, op, a, b,
      output busy, done, result, state
   );
endinterface

// File: rtl/seq_mul32.sv
// Iterative 32-bit shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Works on operand magnitudes for 32 cycles, then sign-corrects the product in one FIX cycle.
module seq_mul32 #(
   parameter int XLEN = 32
) (
   input logic     clk,
   input logic     rst_n,
   seq_mul32_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t            state, state_n;
   logic [1:0]        op_q;
   logic              neg_q;
   logic [XLEN-1:0]   mcand;
   logic [XLEN-1:0]   mplier;
   logic [XLEN-1:0]   acc_hi;
   logic [4:0]        count;
   logic [XLEN-1:0]   result_q;

   logic              accept;
   logic              sa, sb;
   logic [XLEN:0]     sum;
   logic [2*XLEN-1:0] prod, prod_fix;

   assign accept = bus.start && !bus.kill && (state == IDLE || state == DONE);

   assign sa = (bus.op == 2'b01 || bus.op == 2'b10) ? bus.a[XLEN-1] : 1'b0;
   assign sb = (bus.op == 2'b01) ? bus.b[XLEN-1] : 1'b0;

   assign sum      = {1'b0, acc_hi} + {1'b0, (mplier[0] ? mcand : '0)};
   assign prod     = {acc_hi, mplier};
   assign prod_fix = neg_q ? -prod : prod;

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (accept) state_n = CALC;
         CALC: if (count == 5'd31) state_n = FIX;
         FIX:  state_n = DONE;
         DONE: state_n = accept ? CALC : IDLE;
         default: state_n = IDLE;
      endcase
      if (bus.kill) state_n = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Datapath: magnitudes latched on accept, sign applied once at the end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         neg_q    <= 1'b0;
         mcand    <= '0;
         mplier   <= '0;
         acc_hi   <= '0;
         count    <= '0;
         result_q <= '0;
      end else if (accept) begin
         op_q   <= bus.op;
         neg_q  <= sa ^ sb;
         mcand  <= sa ? -bus.a : bus.a;
         mplier <= sb ? -bus.b : bus.b;
         acc_hi <= '0;
         count  <= '0;
      end else if (!bus.kill && state == CALC) begin
         {acc_hi, mplier} <= {sum, mplier[XLEN-1:1]};
         count            <= count + 5'd1;
      end else if (!bus.kill && state == FIX) begin
         result_q <= (op_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      end
   end

   assign bus.busy   = (state == CALC) || (state == FIX);
   assign bus.done   = (state == DONE);
   assign bus.result = result_q;
   assign bus.state  = state;

endmodule

// File: tb/tb_seq_mul32.sv
// Self-checking bench for seq_mul32: directed vector table, random ops against a
// 64-bit arithmetic reference, and hand sequences for kill, back-to-back and reset.
module tb_seq_mul32;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;
   logic [31:0] last_exp;

   seq_mul32_if bus ();

   seq_mul32 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [11];

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
      eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ea * eb;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge of the done cycle (or after the bound).
   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      int n, busy_n;
      logic got;
      bus.start = 1'b1;
      bus.op = op;
      bus.a = a;
      bus.b = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.op = 2'($urandom);
      bus.a = $urandom;
      bus.b = $urandom;
      n = 1;
      busy_n = 0;
      got = 1'b0;
      while (n <= 100 && !got) begin
         if (bus.done) got = 1'b1;
         else begin
            if (bus.busy) busy_n++;
            @(negedge clk);
            n++;
         end
      end
      check({name, " done_seen"}, 64'(got), 64'd1);
      check({name, " result"}, 64'(bus.result), 64'(exp));
      check({name, " done_cycle"}, 64'(n), 64'd34);
      check({name, " busy_cycles"}, 64'(busy_n), 64'd33);
      check({name, " busy_in_done"}, 64'(bus.busy), 64'd0);
      last_exp = exp;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, m, done_cnt;
      logic [1:0] rop;
      logic [31:0] ra, rb;

      vectors = 0;
      miscompares = 0;
      last_exp = '0;

      vecs[0]  = '{2'b00, 32'd7,         32'd6,         32'h0000002A};
      vecs[1]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
      vecs[2]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
      vecs[3]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
      vecs[4]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      vecs[5]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
      vecs[6]  = '{2'b01, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF};
      vecs[7]  = '{2'b01, 32'h00000000, 32'hFFFFFFFB, 32'h00000000};
      vecs[8]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
      vecs[9]  = '{2'b11, 32'h80000000, 32'h00000002, 32'h00000001};
      vecs[10] = '{2'b00, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};

      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.kill = 1'b0;
      bus.op = 2'b00;
      bus.a = '0;
      bus.b = '0;
      repeat (3) @(negedge clk);
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset done", 64'(bus.done), 64'd0);
      check("reset result", 64'(bus.result), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++)
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

      for (int i = 0; i < 24; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         if (i % 8 == 0) ra = 32'h80000000;
         if (i % 8 == 1) rb = 32'h80000000;
         run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb));
      end

      // Kill 10 cycles into an operation: no done, result keeps the previous value.
      bus.start = 1'b1;
      bus.op = 2'b00;
      bus.a = 32'd3;
      bus.b = 32'd9;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      bus.kill = 1'b1;
      @(negedge clk);
      bus.kill = 1'b0;
      check("kill busy_after", 64'(bus.busy), 64'd0);
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) done_cnt++;
         @(negedge clk);
      end
      check("kill no_done", 64'(done_cnt), 64'd0);
      check("kill result_held", 64'(bus.result), 64'(last_exp));

      bus.start = 1'b1;
      bus.kill = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.kill = 1'b0;
      check("start_with_kill busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      check("start_with_kill done", 64'(bus.done), 64'd0);
      run_op("after_kill", 2'b00, 32'd11, 32'd13, 32'd143);

      // Back-to-back: start held through DONE picks up the operands present then.
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = 2'b00;
      bus.a = 32'd7;
      bus.b = 32'd6;
      @(negedge clk);
      bus.a = 32'd100;
      bus.b = 32'd200;
      n = 1;
      while (n <= 100 && !bus.done) begin
         @(negedge clk);
         n++;
      end
      check("b2b first done_cycle", 64'(n), 64'd34);
      check("b2b first result", 64'(bus.result), 64'd42);
      @(negedge clk);
      check("b2b no_bubble busy", 64'(bus.busy), 64'd1);
      m = 1;
      for (int i = 0; i < 5; i++) begin
         bus.start = i[0];
         bus.a = $urandom;
         bus.b = $urandom;
         @(negedge clk);
         m++;
      end
      bus.start = 1'b0;
      while (m <= 100 && !bus.done) begin
         @(negedge clk);
         m++;
      end
      check("b2b second done_cycle", 64'(m), 64'd34);
      check("b2b second result", 64'(bus.result), 64'd20000);
      last_exp = 32'd20000;

      // Reset mid-operation acts without a clock edge.
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = 2'b00;
      bus.a = 32'd1234;
      bus.b = 32'd5678;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (15) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset busy", 64'(bus.busy), 64'd0);
      check("async_reset done", 64'(bus.done), 64'd0);
      check("async_reset result", 64'(bus.result), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_reset", 2'b00, 32'd3, 32'd5, 32'h0000000F);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
